// File: rtl/psr_flag_register_if.sv
// Bus bundle for the PSR flag register: EX-stage flag inputs, condition query, exception save/restore and status outputs.
interface psr_flag_register_if;
  logic       ex_valid_in;
  logic       s_update_in;
  logic       stall_in;
  logic       flush_in;
  logic       N_ALU_in;
  logic       Z_ALU_in;
  logic       C_ALU_in;
  logic       V_ALU_in;
  logic [3:0] cond_in;
  logic       save_in;
  logic       restore_in;
  logic       N_PSR_out;
  logic       Z_PSR_out;
  logic       C_PSR_out;
  logic       V_PSR_out;
  logic       cond_true_out;
  logic       saved_out;
  logic       err_out;

  modport master (
    output ex_valid_in, s_update_in, stall_in, flush_in,
    output N_ALU_in, Z_ALU_in, C_ALU_in, V_ALU_in,
    output cond_in, save_in, restore_in,
    input  N_PSR_out, Z_PSR_out, C_PSR_out, V_PSR_out,
    input  cond_true_out, saved_out, err_out
  );

  modport slave (
    input  ex_valid_in, s_update_in, stall_in, flush_in,
    input  N_ALU_in, Z_ALU_in, C_ALU_in, V_ALU_in,
    input  cond_in, save_in, restore_in,
    output N_PSR_out, Z_PSR_out, C_PSR_out, V_PSR_out,
    output cond_true_out, saved_out, err_out
  );
endinterface

// File: rtl/psr_flag_register.sv
// Architectural NZCV status register with same-cycle forwarding for condition evaluation
// and a one-deep shadow copy for exception entry/return.
module psr_flag_register #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  psr_flag_register_if.slave   bus
);

  typedef enum logic {IDLE, SAVED} state_e;

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic [3:0] shadow_q, shadow_d;
  logic       err_q, err_d;
  logic       upd;
  logic [3:0] alu;
  logic [3:0] eff;
  logic       save_go, restore_go;
  logic       n, z, c, v;

  assign alu = {bus.N_ALU_in, bus.Z_ALU_in, bus.C_ALU_in, bus.V_ALU_in};
  assign upd = bus.ex_valid_in & bus.s_update_in & ~bus.stall_in & ~bus.flush_in;
  assign eff = upd ? alu : flags_q;
  assign {n, z, c, v} = eff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      flags_q  <= RESET_FLAGS;
      shadow_q <= RESET_FLAGS;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.save_in && !bus.restore_in) state_d = SAVED;
      SAVED:   if (bus.restore_in && !bus.save_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Only the single legal request per state acts; any other save/restore request raises err.
  always_comb begin
    save_go    = (state_q == IDLE)  && bus.save_in    && !bus.restore_in;
    restore_go = (state_q == SAVED) && bus.restore_in && !bus.save_in;
    err_d      = (bus.save_in | bus.restore_in) & ~(save_go | restore_go);
  end

  always_comb begin
    flags_d  = restore_go ? shadow_q : eff;
    shadow_d = save_go ? eff : shadow_q;
  end

  always_comb begin
    bus.cond_true_out = 1'b0;
    case (bus.cond_in)
      4'h0: bus.cond_true_out = z;
      4'h1: bus.cond_true_out = ~z;
      4'h2: bus.cond_true_out = c;
      4'h3: bus.cond_true_out = ~c;
      4'h4: bus.cond_true_out = n;
      4'h5: bus.cond_true_out = ~n;
      4'h6: bus.cond_true_out = v;
      4'h7: bus.cond_true_out = ~v;
      4'h8: bus.cond_true_out = c & ~z;
      4'h9: bus.cond_true_out = ~c | z;
      4'hA: bus.cond_true_out = (n == v);
      4'hB: bus.cond_true_out = (n != v);
      4'hC: bus.cond_true_out = ~z & (n == v);
      4'hD: bus.cond_true_out = z | (n != v);
      4'hE: bus.cond_true_out = 1'b1;
      default: bus.cond_true_out = 1'b0;
    endcase
  end

  assign {bus.N_PSR_out, bus.Z_PSR_out, bus.C_PSR_out, bus.V_PSR_out} = flags_q;
  assign bus.saved_out = (state_q == SAVED);
  assign bus.err_out   = err_q;

endmodule
